trace_transmitter: RTL

Serial debug-trace transmitter for the 8-bit microcomputer. On each single-step strobe from the control unit it captures the program counter, current OP code and CPU register R16, then sends them to a host over a UART line (8N1, LSB first). It is the off-board counterpart of the 7-segment/LED step display: the display shows state locally, this block delivers the same state to a host reader. It sits beside the display logic, driven by the same snapshot signals.

---
 rtl/trace_transmitter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/trace_transmitter.sv
// Debug-trace UART transmitter: on an accepted step strobe it snapshots pc, op_code and r16
// and sends a 5-byte frame (A5, pc, op_code, r16, xor checksum) as 8N1, LSB first.
module trace_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       strobe,
  input  logic [7:0] pc,
  input  logic [7:0] op_code,
  input  logic [7:0] r16,
  output logic       tx,
  output logic       busy,
  output logic [7:0] dropped_count
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [2:0]    byte_idx, byte_next;
  logic [7:0]    snap_pc, snap_op, snap_r16;
  logic [7:0]    frame_byte;
  logic          bit_end, accept, drop, tx_next, busy_next;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = baud_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    accept     = 1'b0;
    drop       = strobe && enable && (state != IDLE);
    bit_end    = (baud_cnt == LAST_TICK);

    case (state)
      IDLE: begin
        if (strobe && enable) begin
          accept     = 1'b1;
          state_next = START;
          cnt_next   = '0;
          bit_next   = '0;
          byte_next  = '0;
        end
      end
      START: begin
        cnt_next = baud_cnt + 1'b1;
        if (bit_end) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        cnt_next = baud_cnt + 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end
      end
      STOP: begin
        cnt_next = baud_cnt + 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (byte_idx < 3'd4) begin
            byte_next  = byte_idx + 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Byte contents come from the snapshot, which is stable before any of its bits go out.
    case (byte_next)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = snap_pc;
      3'd2:    frame_byte = snap_op;
      3'd3:    frame_byte = snap_r16;
      default: frame_byte = snap_pc ^ snap_op ^ snap_r16;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = frame_byte[bit_next];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make every register update from the same pre-edge values.
    if (reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      snap_pc       <= '0;
      snap_op       <= '0;
      snap_r16      <= '0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      dropped_count <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      tx       <= tx_next;
      busy     <= busy_next;
      if (accept) begin
        snap_pc  <= pc;
        snap_op  <= op_code;
        snap_r16 <= r16;
      end
      if (drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
    end
  end

endmodule
